i2c_reg_slave: RTL and testbench
================================

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h42, 7-bit I2C address this slave answers.
REQ-002 Parameter NUM_REGS, default 16, register file depth; power of two, 2..256.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer flops on scl/sda inputs; minimum 2.
REQ-004 sysclk  in  1  sole clock; every flop on posedge sysclk.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 scl_in  in  1  I2C clock pin, asynchronous.
REQ-007 sda_in  in  1  I2C data pin read-back, asynchronous.
REQ-008 sda_oe  out  1  1 = pull SDA low; 0 = release (open-drain; top level builds the tristate).
REQ-009 host_we, host_addr[$clog2(NUM_REGS)-1:0], host_wdata[7:0]  in  local write port.
REQ-010 host_rdata  out  8  reg[host_addr], combinational read.
REQ-011 i2c_wr_stb  out  1  one-cycle pulse when an I2C data byte is written; i2c_wr_addr/i2c_wr_data (out, index width/8) qualify it.
REQ-012 busy  out  1  high from an addressed START until STOP.
REQ-013 state_dbg  out  4  current FSM state encoding, for 7-segment debug.

Function
REQ-014 scl_in/sda_in pass through SYNC_STAGES flops; rise/fall detection uses only synchronized values.
REQ-015 START = synchronized SDA fall while SCL high; STOP = SDA rise while SCL high; both recognized in every state, including mid-byte.
REQ-016 SDA sampled on SCL rise; sda_oe updated on the sysclk after a detected SCL fall; never changed while SCL high except by reset/START/STOP (which force sda_oe=0).
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-018 IDLE -START-> ADDR; bits MSB first, 8th bit = R/W.
REQ-019 Address match: drive ACK (sda_oe=1) in 9th clock, then W -> PTR, R -> RDATA; mismatch: no ACK -> WAIT_STOP.
REQ-020 PTR: received byte modulo NUM_REGS loads the pointer; ACK; -> WDATA.
REQ-021 WDATA: byte written to reg[ptr] at 8th SCL rise, i2c_wr_stb pulses that cycle; ACK; ptr increments, wraps NUM_REGS-1 -> 0.
REQ-022 RDATA: reg[ptr] latched into shift register at entry (after address ACK / after master ACK); MSB driven first (sda_oe = ~bit); SDA released in 9th clock.
REQ-023 RDATA_ACK: master ACK (SDA low at 9th rise) -> ptr+1 with wrap, next byte; NACK -> WAIT_STOP, SDA released.
REQ-024 Repeated START in any state -> ADDR, pointer retained; STOP -> IDLE, pointer retained.
REQ-025 Host write and I2C write to same register in same cycle: host write wins, i2c_wr_stb still pulses.
REQ-026 Pointer write through host port not provided; host reads never disturb I2C transfer.
REQ-027 busy asserts at address-ACK cycle, deasserts on STOP or on START not matching address.

Reset
REQ-028 rst: state IDLE, sda_oe 0, busy 0, i2c_wr_stb 0, ptr 0, shift/bit counters 0, all registers 8'h00, synchronizers to 1 (idle bus).
REQ-029 rst mid-transfer aborts immediately; next transfer needs a fresh START.

Structure
REQ-030 Package i2c_slave_pkg: state enum (4-bit, matching state_dbg), I2C_ACK/I2C_NACK constants, byte width 8.
REQ-031 One sub-module i2c_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulses, instantiated once each for SCL and SDA.

Verification
REQ-032 Write 0x84,0x03,0xA5,0x5A, STOP -> ACK on all bytes; reg[3]=A5, reg[4]=5A; two i2c_wr_stb pulses, addr 3 then 4.
REQ-033 Write 0x84,0x0F; Sr; 0x85; read 3 bytes ACK,ACK,NACK -> returns reg[15],reg[0],reg[1] (wrap); SDA released after NACK.
REQ-034 Address 0x90 (7'h48) write -> no ACK, state WAIT_STOP, busy 0, no register changes.
REQ-035 host_we to reg[5]=0x11 same cycle as I2C write reg[5]=0x22 -> reg[5]=0x11, stb pulses.
REQ-036 rst asserted during 5th data bit of read -> sda_oe=0 next cycle, IDLE, all regs 0; following full write transfer succeeds.
REQ-037 STOP issued after 4 bits of a data byte -> IDLE, partial byte discarded, no i2c_wr_stb.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register slave: FSM state encoding
// (also exported on state_dbg), ACK/NACK bus levels and the byte width.
package i2c_slave_pkg;

  localparam int BYTE_W = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for an asynchronous bus pin, with single-cycle
// rise/fall pulses derived from the synchronized level only.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   prev_p1;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync_p0 <= '1;
      prev_p1 <= 1'b1;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], pin};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign level = sync_p0[SYNC_STAGES-1];
  assign rise  = level & ~prev_p1;
  assign fall  = ~level & prev_p1;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave exposing a byte register file: write sets pointer then data,
// read streams from the pointer with auto-increment; local host port on the side.
module i2c_reg_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                        sysclk,
  input  logic                        rst,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  input  logic                        host_we,
  input  logic [$clog2(NUM_REGS)-1:0] host_addr,
  input  logic [BYTE_W-1:0]           host_wdata,
  output logic [BYTE_W-1:0]           host_rdata,
  output logic                        i2c_wr_stb,
  output logic [$clog2(NUM_REGS)-1:0] i2c_wr_addr,
  output logic [BYTE_W-1:0]           i2c_wr_data,
  output logic                        busy,
  output logic [3:0]                  state_dbg
);

  localparam int AW = $clog2(NUM_REGS);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .sysclk (sysclk),
    .rst    (rst),
    .pin    (scl_in),
    .level  (scl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .sysclk (sysclk),
    .rst    (rst),
    .pin    (sda_in),
    .level  (sda),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;

  logic [BYTE_W-1:0] regs [NUM_REGS];

  state_t            state, state_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0] shift, shift_n;
  logic [BYTE_W-1:0] tx, tx_n;
  logic              rw, rw_n;
  logic [AW-1:0]     ptr, ptr_n, ptr_inc;
  logic              sda_oe_n, busy_n, stb_n;
  logic [AW-1:0]     wr_addr_n;
  logic [BYTE_W-1:0] wr_data_n;
  logic [BYTE_W-1:0] rd_cur, rd_nxt;

  assign ptr_inc = ptr + 1'b1;
  assign rd_cur  = regs[ptr];
  assign rd_nxt  = regs[ptr_inc];

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    tx_n      = tx;
    rw_n      = rw;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    stb_n     = 1'b0;
    wr_addr_n = i2c_wr_addr;
    wr_data_n = i2c_wr_data;

    if (stop_det) begin
      state_n   = ST_IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
      shift_n   = '0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_n   = {shift[BYTE_W-2:0], sda};
            bit_cnt_n = bit_cnt + 4'd1;
            // The data byte is committed on its 8th rising edge.
            if (state == ST_WDATA && bit_cnt == 4'd7) begin
              stb_n     = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = {shift[BYTE_W-2:0], sda};
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_n = '0;
            if (state == ST_ADDR) begin
              if (shift[7:1] == SLAVE_ADDR) begin
                state_n  = ST_ADDR_ACK;
                sda_oe_n = 1'b1;
                busy_n   = 1'b1;
                rw_n     = shift[0];
              end else begin
                state_n  = ST_WAIT_STOP;
                busy_n   = 1'b0;
              end
            end else if (state == ST_PTR) begin
              ptr_n    = shift[AW-1:0];
              state_n  = ST_PTR_ACK;
              sda_oe_n = 1'b1;
            end else begin
              ptr_n    = ptr_inc;
              state_n  = ST_WDATA_ACK;
              sda_oe_n = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw) begin
              state_n  = ST_RDATA;
              tx_n     = {rd_cur[BYTE_W-2:0], 1'b0};
              sda_oe_n = ~rd_cur[BYTE_W-1];
            end else begin
              state_n  = ST_PTR;
              sda_oe_n = 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_n  = ST_WDATA;
            sda_oe_n = 1'b0;
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              state_n   = ST_RDATA_ACK;
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
            end else begin
              tx_n     = {tx[BYTE_W-2:0], 1'b0};
              sda_oe_n = ~tx[BYTE_W-1];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            shift_n = {shift[BYTE_W-2:0], sda};
          end else if (scl_fall) begin
            if (shift[0] == I2C_ACK) begin
              state_n  = ST_RDATA;
              ptr_n    = ptr_inc;
              tx_n     = {rd_nxt[BYTE_W-2:0], 1'b0};
              sda_oe_n = ~rd_nxt[BYTE_W-1];
            end else begin
              state_n  = ST_WAIT_STOP;
              sda_oe_n = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= '0;
      rw         <= 1'b0;
      ptr        <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      i2c_wr_stb <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      tx         <= tx_n;
      rw         <= rw_n;
      ptr        <= ptr_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      i2c_wr_stb <= stb_n;
    end
  end

  always_ff @(posedge sysclk) begin
    i2c_wr_addr <= wr_addr_n;
    i2c_wr_data <= wr_data_n;
  end

  // Host write is issued last so it overrides a same-cycle I2C write.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (i2c_wr_stb) regs[i2c_wr_addr] <= i2c_wr_data;
      if (host_we)    regs[host_addr]   <= host_wdata;
    end
  end

  assign host_rdata = regs[host_addr];
  assign state_dbg  = state;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed/randomized bench for i2c_reg_slave: bit-banged I2C master plus a
// byte-level register-file model and expected write-strobe queue.
module tb_i2c_reg_slave;

  localparam int NUM_REGS = 16;
  localparam int AW       = 4;
  localparam int T        = 100;
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  typedef logic [7:0] byte_q_t [$];

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          m_scl = 1'b1;
  logic          m_sda = 1'b1;
  logic          sda_in;
  logic          sda_oe;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic [7:0]    host_rdata;
  logic          i2c_wr_stb;
  logic [AW-1:0] i2c_wr_addr;
  logic [7:0]    i2c_wr_data;
  logic          busy;
  logic [3:0]    state_dbg;

  assign sda_in = m_sda & ~sda_oe;

  always #5 sysclk = ~sysclk;

  i2c_reg_slave #(.SLAVE_ADDR(7'h42), .NUM_REGS(NUM_REGS), .SYNC_STAGES(2)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .scl_in      (m_scl),
    .sda_in      (sda_in),
    .sda_oe      (sda_oe),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .i2c_wr_stb  (i2c_wr_stb),
    .i2c_wr_addr (i2c_wr_addr),
    .i2c_wr_data (i2c_wr_data),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]    mregs [NUM_REGS];
  int            mptr;
  logic [AW+7:0] stb_q [$];
  logic [AW+7:0] exp_q [$];

  always @(negedge sysclk) if (!rst && i2c_wr_stb) stb_q.push_back({i2c_wr_addr, i2c_wr_data});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;  #(T);
    m_scl = 1'b1; #(T);
    s = sda_in; #(T);
    m_scl = 1'b0; #(T);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; #(T);
    m_scl = 1'b1; #(T);
    m_sda = 1'b0; #(T);
    m_scl = 1'b0; #(T);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; #(T);
    m_scl = 1'b1; #(T);
    m_sda = 1'b1; #(2*T);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
  endtask

  task automatic rd_check(input logic nack, input string tag);
    logic [7:0] d;
    rd_byte(nack, d);
    check(tag, d, mregs[mptr]);
    if (!nack) mptr = (mptr + 1) % NUM_REGS;
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    @(posedge sysclk); #1;
    host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
    @(posedge sysclk); #1;
    host_we = 1'b0;
    mregs[a] = d;
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      host_addr = AW'(i); #1;
      check($sformatf("%s reg%0d", tag, i), host_rdata, mregs[i]);
    end
  endtask

  task automatic check_stb(input string tag);
    check({tag, " stb_count"}, stb_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
      check($sformatf("%s stb%0d", tag, i), stb_q[i], exp_q[i]);
    stb_q.delete();
    exp_q.delete();
  endtask

  task automatic write_txn(input int p, input byte_q_t data, input string tag);
    logic ack;
    i2c_start;
    wr_byte(8'h84, ack);
    check({tag, " addr_ack"}, ack, 1'b0);
    check({tag, " busy_on"}, busy, 1'b1);
    wr_byte(8'(p), ack);
    check({tag, " ptr_ack"}, ack, 1'b0);
    mptr = p % NUM_REGS;
    foreach (data[k]) begin
      wr_byte(data[k], ack);
      check({tag, " data_ack"}, ack, 1'b0);
      mregs[mptr] = data[k];
      exp_q.push_back({AW'(mptr), data[k]});
      mptr = (mptr + 1) % NUM_REGS;
    end
    i2c_stop;
    check({tag, " idle_after_stop"}, state_dbg, S_IDLE);
    check({tag, " busy_off"}, busy, 1'b0);
  endtask

  task automatic read_txn(input int n, input string tag);
    logic ack;
    i2c_start;
    wr_byte(8'h85, ack);
    check({tag, " raddr_ack"}, ack, 1'b0);
    for (int k = 0; k < n; k++) rd_check(k == n - 1, $sformatf("%s rd%0d", tag, k));
    check({tag, " released"}, sda_oe, 1'b0);
    i2c_stop;
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d, partial;
    logic [3:0] hi;
    bit         seen;
    byte_q_t    q;

    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    repeat (5) @(posedge sysclk);
    #1 rst = 1'b0;
    repeat (5) @(posedge sysclk);
    #1;
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst stb", i2c_wr_stb, 1'b0);
    check("rst state", state_dbg, S_IDLE);
    check_all_regs("rst");

    q = '{8'hA5, 8'h5A};
    write_txn(3, q, "w_basic");
    check_all_regs("w_basic");
    check_stb("w_basic");

    for (int r = 0; r < 3; r++) begin
      q.delete();
      repeat ($urandom_range(1, 5)) q.push_back(8'($urandom));
      write_txn($urandom_range(0, 255), q, $sformatf("w_rand%0d", r));
    end
    check_all_regs("w_rand");
    check_stb("w_rand");

    host_write(15, 8'($urandom));
    host_write(0, 8'($urandom));
    host_write(1, 8'($urandom));
    i2c_start;
    wr_byte(8'h84, ack); check("wrap addr_ack", ack, 1'b0);
    wr_byte(8'h0F, ack); check("wrap ptr_ack", ack, 1'b0);
    mptr = 15;
    i2c_start;
    wr_byte(8'h85, ack); check("wrap raddr_ack", ack, 1'b0);
    check("wrap busy", busy, 1'b1);
    rd_check(1'b0, "wrap rd15");
    rd_check(1'b0, "wrap rd0");
    rd_check(1'b1, "wrap rd1");
    check("wrap sda_oe_released", sda_oe, 1'b0);
    check("wrap sda_high", sda_in, 1'b1);
    check("wrap wait_stop", state_dbg, S_WAIT_STOP);
    i2c_stop;
    check("wrap idle", state_dbg, S_IDLE);
    check("wrap busy_off", busy, 1'b0);

    i2c_start;
    wr_byte(8'h84, ack); check("nomatch first_ack", ack, 1'b0);
    check("nomatch busy_on", busy, 1'b1);
    i2c_start;
    wr_byte(8'h90, ack); check("nomatch nack", ack, 1'b1);
    check("nomatch state", state_dbg, S_WAIT_STOP);
    check("nomatch busy", busy, 1'b0);
    wr_byte(8'($urandom), ack); check("nomatch ignored", ack, 1'b1);
    i2c_stop;
    check("nomatch idle", state_dbg, S_IDLE);
    check_all_regs("nomatch");
    check_stb("nomatch");

    seen = 1'b0;
    fork
      begin
        logic a0, a1, a2;
        i2c_start;
        wr_byte(8'h84, a0);
        wr_byte(8'h05, a1);
        wr_byte(8'h22, a2);
        i2c_stop;
        ack = a0 | a1 | a2;
      end
      begin
        for (int c = 0; c < 5000 && !seen; c++) begin
          @(posedge sysclk); #1;
          if (i2c_wr_stb) begin
            host_we = 1'b1; host_addr = AW'(5); host_wdata = 8'h11;
            @(posedge sysclk); #1;
            host_we = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    check("collide acks", ack, 1'b0);
    check("collide stb_seen", seen, 1'b1);
    mregs[5] = 8'h11;
    exp_q.push_back({AW'(5), 8'h22});
    mptr = 6;
    check_all_regs("collide");
    check_stb("collide");

    d = 8'($urandom);
    i2c_start;
    wr_byte(8'h84, ack); check("partial addr_ack", ack, 1'b0);
    wr_byte(d, ack);     check("partial ptr_ack", ack, 1'b0);
    mptr = d % NUM_REGS;
    partial = 8'($urandom);
    for (int i = 7; i >= 4; i--) clk_bit(partial[i], s);
    i2c_stop;
    check("partial idle", state_dbg, S_IDLE);
    check("partial busy", busy, 1'b0);
    check_all_regs("partial");
    check_stb("partial");
    read_txn($urandom_range(1, 4), "ptr_kept");

    for (int r = 0; r < 2; r++) begin
      d = 8'($urandom);
      i2c_start;
      wr_byte(8'h84, ack); check("rrand addr_ack", ack, 1'b0);
      wr_byte(d, ack);     check("rrand ptr_ack", ack, 1'b0);
      mptr = d % NUM_REGS;
      read_txn($urandom_range(1, 5), $sformatf("rrand%0d", r));
    end

    host_write(2, 8'($urandom) & 8'hF7);
    i2c_start;
    wr_byte(8'h84, ack); check("abort addr_ack", ack, 1'b0);
    wr_byte(8'h02, ack); check("abort ptr_ack", ack, 1'b0);
    i2c_start;
    wr_byte(8'h85, ack); check("abort raddr_ack", ack, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      clk_bit(1'b1, s);
      hi[i] = s;
    end
    check("abort first_nibble", hi, mregs[2][7:4]);
    m_sda = 1'b1; #(T);
    m_scl = 1'b1; #(T);
    check("abort driving_bit4", sda_oe, 1'b1);
    @(posedge sysclk); #1;
    rst = 1'b1;
    @(posedge sysclk); #1;
    check("abort sda_oe", sda_oe, 1'b0);
    check("abort state", state_dbg, S_IDLE);
    check("abort busy", busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) mregs[i] = 8'h00;
    mptr = 0;
    stb_q.delete();
    exp_q.delete();
    m_scl = 1'b0; #(T);
    i2c_stop;
    check_all_regs("abort");
    q.delete();
    repeat (3) q.push_back(8'($urandom));
    write_txn($urandom_range(0, 255), q, "after_abort");
    check_all_regs("after_abort");
    check_stb("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
